// File: rtl/uart_pkg.sv
// Shared UART definitions: state encoding, oversampling rate and default frame shape.
// The PARITY state exists only when UART_TX_PARITY_EN is defined.
package uart_pkg;

  localparam int unsigned OVERSAMPLE  = 16;
  localparam int unsigned DBIT_DEF    = 8;
  localparam int unsigned SB_TICK_DEF = 16;

`ifdef UART_TX_PARITY_EN
  typedef enum logic [2:0] {ST_IDLE, ST_START, ST_DATA, ST_PARITY, ST_STOP} uart_state_e;
`else
  typedef enum logic [1:0] {ST_IDLE, ST_START, ST_DATA, ST_STOP} uart_state_e;
`endif

endpackage

// File: rtl/uart_tx.sv
// UART transmitter: 16x oversampled, LSB first, optional parity bit (UART_TX_PARITY_EN).
// Pops the upstream FIFO via tx_done_tick; baud tick comes from an external shared generator.
module uart_tx
  import uart_pkg::*;
#(
  parameter int unsigned DBIT       = DBIT_DEF,
  parameter int unsigned SB_TICK    = SB_TICK_DEF,
  parameter bit          PARITY_ODD = 1'b0
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            tx_start,
  input  logic            s_tick,
  input  logic [DBIT-1:0] din,
  output logic            tx_done_tick,
  output logic            tx,
  output logic            busy
);

  localparam int unsigned SW = ($clog2(SB_TICK) > 4) ? $clog2(SB_TICK) : 4;
  localparam int unsigned NW = $clog2(DBIT);

  localparam logic [SW-1:0] S_BIT_LAST  = SW'(OVERSAMPLE - 1);
  localparam logic [SW-1:0] S_STOP_LAST = SW'(SB_TICK - 1);
  localparam logic [NW-1:0] N_LAST      = NW'(DBIT - 1);

  uart_state_e     state_q;
  logic [SW-1:0]   s_q;
  logic [NW-1:0]   n_q;
  logic [DBIT-1:0] b_q;
  logic            tx_q;
  logic            done_q;
  logic            busy_q;
  logic            line_c;

`ifdef UART_TX_PARITY_EN
  logic            par_q;
`else
  if (PARITY_ODD) begin : g_parity_odd_ignored
  end
`endif

  // Line value of the current state; registered into tx one clk later.
  always_comb begin
    line_c = 1'b1;
    case (state_q)
      ST_START:  line_c = 1'b0;
      ST_DATA:   line_c = b_q[0];
`ifdef UART_TX_PARITY_EN
      ST_PARITY: line_c = par_q;
`endif
      default:   line_c = 1'b1;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      s_q     <= '0;
      n_q     <= '0;
      b_q     <= '0;
      tx_q    <= 1'b1;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
`ifdef UART_TX_PARITY_EN
      par_q   <= 1'b0;
`endif
    end else begin
      tx_q   <= line_c;
      done_q <= 1'b0;
      case (state_q)
        // The cycle right after a pop is skipped so the FIFO can refresh empty and din.
        ST_IDLE: begin
          if (tx_start && !done_q) begin
            state_q <= ST_START;
            s_q     <= '0;
            b_q     <= din;
            busy_q  <= 1'b1;
`ifdef UART_TX_PARITY_EN
            par_q   <= (^din) ^ PARITY_ODD;
`endif
          end
        end
        ST_START: begin
          if (s_tick) begin
            if (s_q == S_BIT_LAST) begin
              s_q     <= '0;
              n_q     <= '0;
              state_q <= ST_DATA;
            end else begin
              s_q <= s_q + SW'(1);
            end
          end
        end
        ST_DATA: begin
          if (s_tick) begin
            if (s_q == S_BIT_LAST) begin
              s_q <= '0;
              b_q <= b_q >> 1;
              if (n_q == N_LAST) begin
`ifdef UART_TX_PARITY_EN
                state_q <= ST_PARITY;
`else
                state_q <= ST_STOP;
`endif
              end else begin
                n_q <= n_q + NW'(1);
              end
            end else begin
              s_q <= s_q + SW'(1);
            end
          end
        end
`ifdef UART_TX_PARITY_EN
        ST_PARITY: begin
          if (s_tick) begin
            if (s_q == S_BIT_LAST) begin
              s_q     <= '0;
              state_q <= ST_STOP;
            end else begin
              s_q <= s_q + SW'(1);
            end
          end
        end
`endif
        ST_STOP: begin
          if (s_tick) begin
            if (s_q == S_STOP_LAST) begin
              state_q <= ST_IDLE;
              done_q  <= 1'b1;
              busy_q  <= 1'b0;
            end else begin
              s_q <= s_q + SW'(1);
            end
          end
        end
        default: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign tx           = tx_q;
  assign tx_done_tick = done_q;
  assign busy         = busy_q;

endmodule
